// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets
// and STATUS bit positions.
package dmem_mmio_pkg;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CYCLE  = 8'h08;
  localparam logic [7:0] OFF_DONE   = 8'h0C;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with pointer wrap and a separate occupancy count.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = mem[rd_ptr];

  // NOTE: storage has no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Memory-stage responder: word RAM with a 256-byte MMIO window holding a TX
// byte FIFO, STATUS, a free-running CYCLE counter and a sticky DONE register.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int          RAM_DEPTH  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        done,
  output logic [31:0] done_code
);

  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       mem [RAM_DEPTH];
  logic [RAM_AW-1:0] ram_idx;
  logic              is_mmio;
  logic [7:0]        off;
  logic              wr_txdata, wr_status, wr_cycle, wr_done;

  logic              fifo_full, fifo_empty, fifo_pop;
  logic [7:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  logic              overflow;
  logic [31:0]       cycle;

  // Byte lanes are ignored: every register is addressed by word.
  assign is_mmio = (a[31:8] == MMIO_BASE[31:8]);
  assign off     = a[7:0] & 8'hFC;
  assign ram_idx = a[RAM_AW+1:2];

  assign wr_txdata = we & is_mmio & (off == OFF_TXDATA);
  assign wr_status = we & is_mmio & (off == OFF_STATUS);
  assign wr_cycle  = we & is_mmio & (off == OFF_CYCLE);
  assign wr_done   = we & is_mmio & (off == OFF_DONE);

  assign tx_valid = ~fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_head;
  assign fifo_pop = tx_valid & tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata),
    .pop   (fifo_pop),
    .din   (wd[7:0]),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (we & ~is_mmio & ~reset) mem[ram_idx] <= wd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      cycle     <= '0;
      done      <= 1'b0;
      done_code <= '0;
    end else begin
      // A dropped push and a clear in the same cycle: the set wins.
      if (wr_txdata & fifo_full & ~fifo_pop)  overflow <= 1'b1;
      else if (wr_status & wd[STAT_OVF])      overflow <= 1'b0;

      // A loaded value already counts the cycle it was written in.
      cycle <= wr_cycle ? wd + 32'd1 : cycle + 32'd1;

      if (wr_done & ~done) begin
        done      <= 1'b1;
        done_code <= wd;
      end
    end
  end

  always_comb begin
    rd = '0;
    if (!is_mmio) begin
      rd = mem[ram_idx];
    end else begin
      case (off)
        OFF_STATUS: begin
          rd[STAT_EMPTY] = (fifo_count == '0);
          rd[STAT_FULL]  = fifo_full;
          rd[STAT_OVF]   = overflow;
        end
        OFF_CYCLE: rd = cycle;
        OFF_DONE:  rd = {31'b0, done};
        default:   rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios plus a randomized run
// compared against a queue/array reference model of the register map.
module tb_dmem_mmio;

  localparam int RAM_DEPTH  = 64;
  localparam int FIFO_DEPTH = 8;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_FF00;
  localparam logic [31:0] A_STATUS = 32'hFFFF_FF04;
  localparam logic [31:0] A_CYCLE  = 32'hFFFF_FF08;
  localparam logic [31:0] A_DONE   = 32'hFFFF_FF0C;

  logic        clk = 1'b0;
  logic        reset, we, tx_ready;
  logic [31:0] a, wd;
  logic [31:0] rd, done_code;
  logic        tx_valid, done;
  logic [7:0]  tx_data;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] ram_m [RAM_DEPTH];
  bit          ram_v [RAM_DEPTH];
  logic [7:0]  q_m [$];
  bit          ovf_m;
  logic [31:0] cyc_m, code_m;
  bit          done_m;

  always #5 clk = ~clk;

  dmem_mmio #(
    .RAM_DEPTH  (RAM_DEPTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_BASE  (32'hFFFF_FF00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .a         (a),
    .wd        (wd),
    .rd        (rd),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .done      (done),
    .done_code (done_code)
  );

  task automatic set_in(input logic r, input logic w, input logic [31:0] addr,
                        input logic [31:0] data, input logic rdy);
    reset = r; we = w; a = addr; wd = data; tx_ready = rdy;
    #1;
  endtask

  // Advance the model by one clock from the current inputs, then clock the DUT.
  task automatic tick();
    bit          mm, pop, full_before;
    logic [7:0]  o;
    int          idx;
    mm  = (a[31:8] == 24'hFFFFFF);
    o   = {a[7:2], 2'b00};
    idx = int'(a[7:2]);
    if (reset) begin
      q_m.delete();
      ovf_m = 0; cyc_m = 0; done_m = 0; code_m = 0;
    end else begin
      pop = (q_m.size() > 0) && tx_ready;
      full_before = (q_m.size() == FIFO_DEPTH);
      if (pop) void'(q_m.pop_front());
      if (we && mm && o == 8'h00) begin
        if (!full_before || pop) q_m.push_back(wd[7:0]);
        else ovf_m = 1;
      end else if (we && mm && o == 8'h04 && wd[2]) begin
        ovf_m = 0;
      end
      cyc_m = (we && mm && o == 8'h08) ? wd + 1 : cyc_m + 1;
      if (we && mm && o == 8'h0C && !done_m) begin
        done_m = 1; code_m = wd;
      end
      if (we && !mm) begin
        ram_m[idx] = wd; ram_v[idx] = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] addr);
    logic [7:0] o;
    o = {addr[7:2], 2'b00};
    if (addr[31:8] != 24'hFFFFFF) return ram_m[addr[7:2]];
    case (o)
      8'h04:   return {29'b0, ovf_m, q_m.size() == FIFO_DEPTH, q_m.size() == 0};
      8'h08:   return cyc_m;
      8'h0C:   return {31'b0, done_m};
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    set_in(1, 0, 0, 0, 0);
    tick(); tick();
    set_in(0, 0, A_STATUS, 0, 0);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (done_code !== 32'h0) begin errors++; $display("FAIL reset_done_code got %h exp 0", done_code); end
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL reset_status got %h exp 1", rd); end
    set_in(0, 0, A_CYCLE, 0, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h exp 0", rd); end
  endtask

  task automatic test_cycle();
    for (int i = 0; i < 5; i++) tick();
    set_in(0, 0, A_CYCLE, 0, 0);
    checks++; if (rd !== 32'd5) begin errors++; $display("FAIL cycle_count got %h exp 5", rd); end
    set_in(0, 1, A_CYCLE, 32'hFFFF_FFFE, 0);
    tick();
    set_in(0, 0, A_CYCLE, 0, 0);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_load got %h exp ffffffff", rd); end
    tick();
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cycle_wrap got %h exp 0", rd); end
  endtask

  task automatic test_ram();
    set_in(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    checks++; if (ram_v[4] && rd !== ram_m[4]) begin errors++; $display("FAIL ram_old_value got %h", rd); end
    tick();
    set_in(0, 0, 32'h10, 0, 0);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_read got %h exp deadbeef", rd); end
    set_in(0, 0, 32'h10 + 4 * RAM_DEPTH, 0, 0);
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias got %h exp deadbeef", rd); end
  endtask

  task automatic test_fifo_order();
    logic [7:0] exp_b [3];
    exp_b = '{8'h41, 8'h42, 8'h43};
    set_in(0, 1, A_TXDATA, 32'h41, 0);
    tick();
    set_in(0, 0, A_STATUS, 0, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL order_status got %h exp 0", rd); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL order_head got %b/%h exp 1/41", tx_valid, tx_data); end
    set_in(0, 1, A_TXDATA, 32'h42, 0); tick();
    set_in(0, 1, A_TXDATA, 32'h43, 0); tick();
    set_in(0, 0, A_STATUS, 0, 0);
    checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL order_stable got %h exp 41", tx_data); end
    set_in(0, 0, A_STATUS, 0, 1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++; $display("FAIL order_drain%0d got %b/%h exp 1/%h", i, tx_valid, tx_data, exp_b[i]);
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL order_empty got %b exp 0", tx_valid); end
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL order_status_empty got %h exp 1", rd); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_b [8];
    exp_b = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h99};
    for (int i = 0; i < 9; i++) begin
      set_in(0, 1, A_TXDATA, 32'h60 + i, 0);
      tick();
    end
    set_in(0, 0, A_STATUS, 0, 0);
    checks++; if (rd !== 32'h6) begin errors++; $display("FAIL ovf_status got %h exp 6", rd); end
    set_in(0, 1, A_STATUS, 32'h4, 0);
    tick();
    set_in(0, 0, A_STATUS, 0, 0);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL ovf_clear got %h exp 2", rd); end
    set_in(0, 1, A_TXDATA, 32'h99, 1);
    checks++; if (tx_data !== 8'h60) begin errors++; $display("FAIL ovf_head got %h exp 60", tx_data); end
    tick();
    set_in(0, 0, A_STATUS, 0, 1);
    checks++; if (rd !== 32'h2) begin errors++; $display("FAIL ovf_full_pushpop got %h exp 2", rd); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_b[i]) begin
        errors++; $display("FAIL ovf_drain%0d got %b/%h exp 1/%h", i, tx_valid, tx_data, exp_b[i]);
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0 || rd !== 32'h1) begin errors++; $display("FAIL ovf_end got %b/%h exp 0/1", tx_valid, rd); end
  endtask

  task automatic test_done();
    set_in(0, 1, A_DONE, 32'd7, 0);
    tick();
    set_in(0, 0, A_DONE, 0, 0);
    checks++; if (done !== 1'b1 || done_code !== 32'd7) begin errors++; $display("FAIL done_set got %b/%h exp 1/7", done, done_code); end
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL done_read got %h exp 1", rd); end
    set_in(0, 1, A_DONE, 32'd9, 0);
    tick();
    checks++; if (done_code !== 32'd7) begin errors++; $display("FAIL done_sticky got %h exp 7", done_code); end
    set_in(1, 0, 0, 0, 0);
    tick();
    set_in(0, 0, A_DONE, 0, 0);
    checks++; if (done !== 1'b0 || done_code !== 32'h0) begin errors++; $display("FAIL done_reset got %b/%h exp 0/0", done, done_code); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, A_TXDATA, 32'hA0 + i, 0);
      tick();
    end
    set_in(1, 1, A_TXDATA, 32'h55, 0);
    tick();
    set_in(0, 0, A_STATUS, 0, 0);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_tx_valid got %b exp 0", tx_valid); end
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL mid_status got %h exp 1", rd); end
    set_in(0, 0, A_CYCLE, 0, 0);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_cycle got %h exp 0", rd); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_no_push got %b exp 0", tx_valid); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [31:0] exp_rd;
    logic [7:0]  exp_tx;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: addr = A_TXDATA;
        1: addr = A_STATUS;
        2: addr = A_CYCLE;
        3: addr = A_DONE;
        4: addr = 32'hFFFF_FF00 | ($urandom_range(4, 63) << 2);
        default: begin
          addr = $urandom();
          if (addr[31:8] == 24'hFFFFFF) addr[31] = 1'b0;
        end
      endcase
      set_in($urandom_range(0, 39) == 0, $urandom_range(0, 1), addr, $urandom(), $urandom_range(0, 1));
      exp_rd = model_rd(addr);
      exp_tx = (q_m.size() > 0) ? q_m[0] : 8'h00;
      if (addr[31:8] == 24'hFFFFFF || ram_v[addr[7:2]]) begin
        checks++;
        if (rd !== exp_rd) begin errors++; $display("FAIL rand_rd n=%0d a=%h got %h exp %h", n, addr, rd, exp_rd); end
      end
      checks++;
      if (tx_valid !== (q_m.size() > 0) || tx_data !== exp_tx) begin
        errors++; $display("FAIL rand_tx n=%0d got %b/%h exp %b/%h", n, tx_valid, tx_data, q_m.size() > 0, exp_tx);
      end
      checks++;
      if (done !== done_m || done_code !== code_m) begin
        errors++; $display("FAIL rand_done n=%0d got %b/%h exp %b/%h", n, done, done_code, done_m, code_m);
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram_v[i] = 0;
    test_reset();
    test_cycle();
    test_ram();
    test_fifo_order();
    test_overflow();
    test_done();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
